// File: rtl/w_ingress_ctrl.sv
// Write-side ingress controller: 2-entry skid buffer in front of the FIFO
// write port, with IDLE/XFER/STALL tracking and debug counters.
module w_ingress_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_w_clk,
    input  logic                  i_wrst,
    input  logic                  i_in_valid,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    input  logic                  i_in_last,
    output logic                  o_in_ready,
    input  logic                  i_full,
    output logic                  o_w_en,
    output logic [DATA_WIDTH-1:0] o_w_data,
    output logic [1:0]            o_state,
    output logic [CNT_WIDTH-1:0]  o_word_cnt,
    output logic [CNT_WIDTH-1:0]  o_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  o_stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_data [0:1];
    logic                  r_last [0:1];
    logic                  r_head;
    logic                  r_tail;
    logic [1:0]            r_count;
    logic [1:0]            w_count_next;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_WIDTH-1:0]  r_word_cnt;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;

    // Ready depends only on registered occupancy, never on FULL
    assign o_in_ready = !i_wrst && (r_count != 2'd2);
    assign o_w_en     = !i_wrst && (r_count != 2'd0) && !i_full;
    assign o_w_data   = r_data[r_head];

    assign w_push       = i_in_valid && o_in_ready;
    assign w_pop        = o_w_en;
    assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

    always_comb begin
        w_state_next = S_IDLE;
        if (w_count_next != 2'd0) begin
            w_state_next = i_full ? S_STALL : S_XFER;
        end
    end

    always_ff @(posedge i_w_clk) begin
        if (i_wrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_w_clk) begin
        if (i_wrst) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_data[r_tail] <= i_in_data;
                r_last[r_tail] <= i_in_last;
                r_tail         <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge i_w_clk) begin
        if (i_wrst) begin
            r_word_cnt  <= '0;
            r_pkt_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
                if (r_last[r_head]) begin
                    r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
                end
            end
            // Stall time saturates rather than wrapping
            if (r_state == S_STALL && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign o_state     = r_state;
    assign o_word_cnt  = r_word_cnt;
    assign o_pkt_cnt   = r_pkt_cnt;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_w_ingress_ctrl.sv
// Scoreboard bench for w_ingress_ctrl; a second instance with 4-bit
// counters covers stall-counter saturation.
module tb_w_ingress_ctrl;

    logic        clk = 1'b0;
    logic        wrst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        full;
    logic        in_ready;
    logic        w_en;
    logic [7:0]  w_data;
    logic [1:0]  state;
    logic [15:0] word_cnt;
    logic [15:0] pkt_cnt;
    logic [15:0] stall_cnt;
    logic        s_in_ready;
    logic        s_w_en;
    logic [7:0]  s_w_data;
    logic [1:0]  s_state;
    logic [3:0]  s_word_cnt;
    logic [3:0]  s_pkt_cnt;
    logic [3:0]  s_stall_cnt;

    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  sb_q[$];
    logic        mon = 1'b0;
    logic        tog = 1'b0;

    always #5 clk = ~clk;

    w_ingress_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .i_w_clk     (clk),
        .i_wrst      (wrst),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .i_in_last   (in_last),
        .o_in_ready  (in_ready),
        .i_full      (full),
        .o_w_en      (w_en),
        .o_w_data    (w_data),
        .o_state     (state),
        .o_word_cnt  (word_cnt),
        .o_pkt_cnt   (pkt_cnt),
        .o_stall_cnt (stall_cnt)
    );

    w_ingress_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_small (
        .i_w_clk     (clk),
        .i_wrst      (wrst),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .i_in_last   (in_last),
        .o_in_ready  (s_in_ready),
        .i_full      (full),
        .o_w_en      (s_w_en),
        .o_w_data    (s_w_data),
        .o_state     (s_state),
        .o_word_cnt  (s_word_cnt),
        .o_pkt_cnt   (s_pkt_cnt),
        .o_stall_cnt (s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: pop on write, push on accept
    always @(negedge clk) begin
        if (mon) begin
            if (w_en) begin
                chk("wen_full", 32'(full), 0);
                if (sb_q.size() == 0) begin
                    chk("spurious_wen", 1, 0);
                end else begin
                    chk("wdata", 32'(w_data), 32'(sb_q.pop_front()));
                end
            end
            if (wrst) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back(in_data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Holds a word until accepted; next cyc() is the accepting edge
    task automatic send(input logic [7:0] d, input logic l);
        int n;
        cyc();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            cyc();
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 1, 0);
    endtask

    task automatic idle(input int n);
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n - 1) cyc();
    endtask

    initial begin
        wrst     = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_last  = 1'b0;
        full     = 1'b0;
        mon      = 1'b1;

        // Reset held with valid asserted
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", 32'(in_ready), 0);
            chk("rst_wen", 32'(w_en), 0);
        end
        chk("rst_state", 32'(state), 0);
        chk("rst_wcnt", 32'(word_cnt), 0);
        chk("rst_pcnt", 32'(pkt_cnt), 0);
        chk("rst_scnt", 32'(stall_cnt), 0);
        cyc();
        wrst     = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rel_ready", 32'(in_ready), 1);

        // Streaming, one word per cycle, 1-cycle latency
        for (int i = 1; i <= 16; i++) begin
            cyc();
            in_valid = 1'b1;
            in_data  = 8'(i);
            in_last  = (i == 8 || i == 16);
            @(negedge clk);
            chk("str_ready", 32'(in_ready), 1);
            chk("str_lat", 32'(w_en), (i > 1) ? 1 : 0);
        end
        idle(3);
        @(negedge clk);
        chk("str_wcnt", 32'(word_cnt), 16);
        chk("str_pcnt", 32'(pkt_cnt), 2);
        chk("str_state", 32'(state), 0);
        chk("str_sb", sb_q.size(), 0);

        // Backpressure with FULL high
        cyc();
        full = 1'b1; in_valid = 1'b1; in_data = 8'hA0; in_last = 1'b0;
        @(negedge clk);
        chk("bp_rdy0", 32'(in_ready), 1);
        cyc();
        in_data = 8'hA1;
        @(negedge clk);
        chk("bp_rdy1", 32'(in_ready), 1);
        chk("bp_wen1", 32'(w_en), 0);
        cyc();
        in_data = 8'hA2;
        @(negedge clk);
        chk("bp_rdy2", 32'(in_ready), 0);
        chk("bp_wen2", 32'(w_en), 0);
        chk("bp_state", 32'(state), 2);
        chk("bp_scnt1", 32'(stall_cnt), 1);
        repeat (3) cyc();
        @(negedge clk);
        chk("bp_scnt4", 32'(stall_cnt), 4);
        chk("bp_rdy_hold", 32'(in_ready), 0);
        cyc();
        full = 1'b0;
        @(negedge clk);
        chk("bp_wen_rise", 32'(w_en), 1);
        chk("bp_rdy_still", 32'(in_ready), 0);
        cyc();
        @(negedge clk);
        chk("bp_rdy_back", 32'(in_ready), 1);
        chk("bp_xfer", 32'(state), 1);
        idle(4);
        @(negedge clk);
        chk("bp_wcnt", 32'(word_cnt), 19);
        chk("bp_sb", sb_q.size(), 0);
        chk("bp_idle", 32'(state), 0);

        // FULL toggling every cycle under continuous input
        tog = 1'b1;
        fork
            while (tog) begin
                cyc();
                full = ~full;
            end
        join_none
        for (int i = 0; i < 32; i++) begin
            send(8'(8'h30 + i), (i % 4) == 3);
        end
        cyc();
        in_valid = 1'b0;
        tog = 1'b0;
        cyc();
        full = 1'b0;
        idle(4);
        @(negedge clk);
        chk("tog_sb", sb_q.size(), 0);
        chk("tog_wcnt", 32'(word_cnt), 51);
        chk("tog_pcnt", 32'(pkt_cnt), 10);

        // Reset with two words buffered
        cyc();
        full = 1'b1;
        send(8'h77, 1'b0);
        send(8'h78, 1'b0);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("mr_rdy_full", 32'(in_ready), 0);
        cyc();
        wrst = 1'b1;
        full = 1'b0;
        @(negedge clk);
        chk("mr_wen_rst", 32'(w_en), 0);
        cyc();
        wrst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mr_wen_post", 32'(w_en), 0);
            cyc();
        end
        chk("mr_wcnt0", 32'(word_cnt), 0);
        send(8'h99, 1'b1);
        idle(3);
        @(negedge clk);
        chk("mr_wcnt1", 32'(word_cnt), 1);
        chk("mr_pcnt1", 32'(pkt_cnt), 1);

        // Stall counter saturation on 4-bit instance
        cyc();
        full = 1'b1;
        send(8'hC3, 1'b0);
        idle(20);
        @(negedge clk);
        chk("sat_15", 32'(s_stall_cnt), 15);
        chk("sat_state", 32'(s_state), 2);
        repeat (2) cyc();
        @(negedge clk);
        chk("sat_hold", 32'(s_stall_cnt), 15);
        cyc();
        full = 1'b0;
        idle(3);
        @(negedge clk);
        chk("sat_sb", sb_q.size(), 0);
        chk("sat_wcnt", 32'(s_word_cnt), 2);

        mon = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
